// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the default instruction/address widths, the frame length field width
// and the loader state encoding used by prog_loader and its byte packer.
package prog_loader_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 8;
    localparam int INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int LEN_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // States in which the loader is consuming frame bytes.
    function automatic logic in_frame(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles a stream of bytes into INSTR_WIDTH-bit words, MSB first.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clear             restart packing at byte 0 (start of a new load)
//   byte_valid        byte_data is consumed this cycle
//   byte_data         incoming byte
//   word_full         this cycle's byte completes a word
//   word_data         the completed word, valid while word_full is high
module byte_packer #(
    parameter int INSTR_WIDTH = prog_loader_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   word_full,
    output logic [INSTR_WIDTH-1:0] word_data
);
    import prog_loader_pkg::*;

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [INSTR_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]       idx;
    logic [INSTR_WIDTH-1:0] shreg_next;

    // The completing byte is merged combinationally so the word is available
    // in the same cycle it is accepted; the caller registers it for the write.
    assign shreg_next = (shreg << 8) | INSTR_WIDTH'(byte_data);
    assign word_data  = shreg_next;
    assign word_full  = byte_valid && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_valid) begin
            shreg <= shreg_next;
            idx   <= word_full ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: fills program memory from a framed byte stream.
// Frame: LEN_HI, LEN_LO (word count N), N*INSTR_BYTES data bytes MSB first,
// then a mod-256 checksum over the length and data bytes. The processor is
// held in reset while a load runs and after a failed load.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a load (taken only in IDLE, DONE, ERR)
//   rx_data/valid     incoming byte stream
//   rx_ready          loader accepts a byte this cycle
//   prog_we/addr/data program memory write port, one strobe per word
//   cpu_hold          keep processor in reset
//   done / error      load finished good / aborted (levels)
//
// state  | meaning
// IDLE   | after reset, nothing loaded
// LEN_HI | waiting for word count high byte
// LEN_LO | waiting for word count low byte, length checked here
// DATA   | receiving instruction bytes, writing each full word
// CSUM   | waiting for checksum byte
// DONE   | load good, processor released
// ERR    | bad length or checksum, processor held
module prog_loader #(
    parameter int INSTR_WIDTH = prog_loader_pkg::INSTR_WIDTH,
    parameter int PC_WIDTH    = prog_loader_pkg::PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   prog_we,
    output logic [PC_WIDTH-1:0]    prog_addr,
    output logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);
    import prog_loader_pkg::*;

    // One extra bit so N == 2**PC_WIDTH is representable for the range check.
    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(2 ** PC_WIDTH);

    loader_state_t state, state_next;

    logic [7:0]             len_hi;
    logic [LEN_WIDTH-1:0]   words_left;
    logic [PC_WIDTH-1:0]    addr;
    logic [7:0]             csum;

    logic                   accept;
    logic                   start_ok;
    logic [LEN_WIDTH-1:0]   len_word;
    logic                   pack_valid;
    logic                   word_full;
    logic [INSTR_WIDTH-1:0] word_data;

    assign accept     = rx_valid && rx_ready;
    assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_word   = {len_hi, rx_data};
    assign pack_valid = accept && (state == DATA);
    assign prog_addr  = addr;

    byte_packer #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word_full  (word_full),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = in_frame(state);
        cpu_hold   = in_frame(state) || (state == ERR);
        done       = (state == DONE);
        error      = (state == ERR);

        case (state)
            IDLE, DONE, ERR: begin
                if (start_ok) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_word == '0) begin
                        state_next = CSUM;
                    end else if ({1'b0, len_word} > MAX_WORDS) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full && (words_left == LEN_WIDTH'(1))) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (rx_data == csum) ? DONE : ERR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: words_left is a down-counter of words still to receive;
    // addr advances after each write and wraps naturally at full capacity.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= '0;
            words_left <= '0;
            addr       <= '0;
            csum       <= '0;
            prog_we    <= 1'b0;
            prog_data  <= '0;
        end else begin
            prog_we <= word_full;
            if (word_full) begin
                prog_data <= word_data;
            end

            if (start_ok) begin
                len_hi     <= '0;
                words_left <= '0;
                addr       <= '0;
                csum       <= '0;
            end else begin
                if (prog_we) begin
                    addr <= addr + PC_WIDTH'(1);
                end
                if (accept && (state != CSUM)) begin
                    csum <= csum + rx_data;
                end
                if (accept && (state == LEN_HI)) begin
                    len_hi <= rx_data;
                end
                if (accept && (state == LEN_LO)) begin
                    words_left <= len_word;
                end
                if (word_full) begin
                    words_left <= words_left - LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    typedef logic [31:0] word_q_t[$];
    typedef logic [7:0]  byte_q_t[$];
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  gap_ready_bad;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (!rst && prog_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", prog_addr, prog_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", prog_addr, e.addr);
                check("write_data", prog_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start, output bit ok);
        int n;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            if (!rx_ready) gap_ready_bad = 1'b1;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        start    = with_start;
        n = 0;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        ok = rx_ready;
        if (!ok) begin
            n_checks++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 expected 1 within 50 cycles");
        end else begin
            tick();
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic load(input word_q_t words, input logic [7:0] csum_delta, input int gap, input int start_at);
        byte_q_t    fr;
        logic [7:0] sum;
        bit         ok;
        int         n;
        n = words.size();
        fr.push_back(8'(n >> 8));
        fr.push_back(8'(n));
        foreach (words[i]) for (int b = 3; b >= 0; b--) fr.push_back(words[i][8*b +: 8]);
        sum = 8'h00;
        foreach (fr[i]) sum = sum + fr[i];
        fr.push_back(sum + csum_delta);
        foreach (words[i]) exp_q.push_back('{addr: 8'(i), data: words[i]});
        pulse_start();
        check("cpu_hold_after_start", {31'b0, cpu_hold}, 32'd1);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], (i == 0) ? 0 : gap, (i == start_at), ok);
            if (!ok) return;
            if (i >= 2 && i < fr.size() - 1 && ((i - 2) % 4) == 3)
                check("we_latency", {31'b0, prog_we}, 32'd1);
        end
        tick();
        tick();
        check("writes_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"},     {31'b0, done},     {31'b0, d});
        check({tag, "_error"},    {31'b0, error},    {31'b0, e});
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, h});
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        word_q_t w;
        bit      ok;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_result("reset", 1'b0, 1'b0, 1'b0);
        check("reset_prog_we",   {31'b0, prog_we}, 32'd0);
        check("reset_prog_addr", prog_addr, 32'd0);
        check("reset_prog_data", prog_data, 32'd0);

        // Good 2-word frame, back-to-back bytes.
        w = '{32'h11223344, 32'h55667788};
        load(w, 8'h00, 0, -1);
        check_result("good", 1'b1, 1'b0, 1'b0);

        // Same frame, checksum off by one: writes still happen, then ERR.
        load(w, 8'h01, 0, -1);
        check_result("badsum", 1'b0, 1'b1, 1'b1);

        // Empty frame from ERR.
        w = {};
        load(w, 8'h00, 0, -1);
        check_result("empty", 1'b1, 1'b0, 1'b0);

        // N = 257 exceeds capacity: ERR right after LEN_LO, no writes.
        pulse_start();
        send_byte(8'h01, 0, 1'b0, ok);
        send_byte(8'h01, 0, 1'b0, ok);
        check_result("toolong", 1'b0, 1'b1, 1'b1);
        repeat (4) tick();

        // Stalled stream: 5 idle cycles before every byte after the first.
        gap_ready_bad = 1'b0;
        w = '{32'hA1B2C3D4, 32'h0F1E2D3C};
        load(w, 8'h00, 5, -1);
        check_result("gaps", 1'b1, 1'b0, 1'b0);
        check("gaps_ready_held", {31'b0, gap_ready_bad}, 32'd0);

        // Reset in the middle of the data phase.
        pulse_start();
        send_byte(8'h00, 0, 1'b0, ok);
        send_byte(8'h01, 0, 1'b0, ok);
        send_byte(8'hDE, 0, 1'b0, ok);
        send_byte(8'hAD, 0, 1'b0, ok);
        send_byte(8'hBE, 0, 1'b0, ok);
        rst = 1'b1;
        tick();
        check_result("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_prog_we",   {31'b0, prog_we}, 32'd0);
        check("midrst_prog_addr", prog_addr, 32'd0);
        rst = 1'b0;
        w = '{32'hCAFEF00D};
        load(w, 8'h00, 0, -1);
        check_result("after_rst", 1'b1, 1'b0, 1'b0);

        // start pulsed during DATA is ignored.
        w = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        load(w, 8'h00, 0, 5);
        check_result("start_in_data", 1'b1, 1'b0, 1'b0);

        // Full capacity: 256 words, last at address FF, counter wraps after.
        w = {};
        for (int i = 0; i < 256; i++) w.push_back({8'(i), ~8'(i), 8'(i * 3), 8'h5A});
        load(w, 8'h00, 0, -1);
        check_result("full", 1'b1, 1'b0, 1'b0);
        check("full_addr_wrapped", prog_addr, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
